alu_req_arbiter: RTL and testbench

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

---
 rtl/alu_req_arbiter.sv | 172 +++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester front end for a combinational ALU: grant, register operands, capture result, hand back.
// Optional macro ALU_ARB_FIXED_PRIORITY_EN: requester 0 always wins ties (default build is round-robin).
module alu_req_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_sel,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r;
    logic               grant_any_s;
    logic               grant_id_s;
    logic [DATA_W-1:0]  grant_a_s;
    logic [DATA_W-1:0]  grant_b_s;
    logic [3:0]         grant_sel_s;
    logic               rsp_carry_s;

    // Carry is only meaningful for the add opcode; every other result reports zero.
    function automatic logic masked_carry(input logic [3:0] sel, input logic carry);
        logic res;
        if (sel == 4'b0000) begin
            res = carry;
        end else begin
            res = 1'b0;
        end
        return res;
    endfunction

`ifdef ALU_ARB_FIXED_PRIORITY_EN
    // Fixed priority: requester 0 wins whenever it is valid.
    always_comb begin
        grant_any_s = req0_valid | req1_valid;
        if (req0_valid) begin
            grant_id_s = 1'b0;
        end else begin
            grant_id_s = 1'b1;
        end
    end
`else
    logic last_grant_r;

    // Round-robin: on a tie, grant whichever requester did not win last time.
    always_comb begin
        grant_any_s = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id_s = ~last_grant_r;
        end else if (req0_valid) begin
            grant_id_s = 1'b0;
        end else begin
            grant_id_s = 1'b1;
        end
    end

    // Remember the most recent winner; reset value 1 lets requester 0 win first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if ((state_r == IDLE) && grant_any_s) begin
            last_grant_r <= grant_id_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    // Operand selection for the winning requester.
    always_comb begin
        grant_a_s   = req0_a;
        grant_b_s   = req0_b;
        grant_sel_s = req0_sel;
        if (grant_id_s) begin
            grant_a_s   = req1_a;
            grant_b_s   = req1_b;
            grant_sel_s = req1_sel;
        end else begin
            grant_a_s   = req0_a;
            grant_b_s   = req0_b;
            grant_sel_s = req0_sel;
        end
    end

    // Readies are combinational so the requester sees acceptance in the grant cycle itself.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && (state_r == IDLE) && grant_any_s) begin
            req0_ready = ~grant_id_s;
            req1_ready = grant_id_s;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    // Carry qualification uses the registered opcode the ALU is currently executing.
    always_comb begin
        rsp_carry_s = masked_carry(alu_sel, alu_carry);
    end

    // Main FSM with registered ALU operands and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            alu_a     <= {DATA_W{1'b0}};
            alu_b     <= {DATA_W{1'b0}};
            alu_sel   <= 4'b0000;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= {DATA_W{1'b0}};
            rsp_carry <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_any_s) begin
                        alu_a   <= grant_a_s;
                        alu_b   <= grant_b_s;
                        alu_sel <= grant_sel_s;
                        rsp_id  <= grant_id_s;
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_carry <= rsp_carry_s;
                    rsp_valid <= 1'b1;
                    state_r   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r   <= RESP;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: table-driven single-requester vectors plus
// hand-written round-robin, backpressure and mid-operation reset sequences.
module tb_alu_req_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_sel, req1_sel;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_sel;
    logic       alu_carry;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry;
    logic [7:0] rsp_data;
    logic       force_c;
    logic [8:0] sum9;
    logic [15:0] prod16;

    int checks;
    int failures;

    alu_req_arbiter #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference combinational ALU; carry comes from a+b regardless of opcode (force_c can raise it).
    always_comb begin
        sum9      = {1'b0, alu_a} + {1'b0, alu_b};
        prod16    = 16'(alu_a) * 16'(alu_b);
        alu_carry = sum9[8] | force_c;
        case (alu_sel)
            4'h0: alu_out = sum9[7:0];
            4'h1: alu_out = alu_a - alu_b;
            4'h2: alu_out = prod16[7:0];
            4'h3: alu_out = (alu_b == 8'h00) ? 8'hFF : (alu_a / alu_b);
            4'h4: alu_out = alu_a << 1;
            4'h5: alu_out = alu_a >> 1;
            4'h6: alu_out = {alu_a[6:0], alu_a[7]};
            4'h7: alu_out = {alu_a[0], alu_a[7:1]};
            4'h8: alu_out = alu_a & alu_b;
            4'h9: alu_out = alu_a | alu_b;
            4'hA: alu_out = alu_a ^ alu_b;
            4'hB: alu_out = ~(alu_a | alu_b);
            4'hC: alu_out = ~(alu_a & alu_b);
            4'hD: alu_out = ~(alu_a ^ alu_b);
            4'hE: alu_out = (alu_a > alu_b) ? 8'h01 : 8'h00;
            4'hF: alu_out = (alu_a == alu_b) ? 8'h01 : 8'h00;
            default: alu_out = 8'h00;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] exp_data;
        logic       exp_carry;
        logic       force_c;
    } vec_t;

    vec_t vecs[10];

    // One isolated transaction: grant in the IDLE cycle, EXEC, RESP two cycles later, back to IDLE.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        rsp_ready = 1'b1;
        force_c   = v.force_c;
        if (v.id) begin
            req1_a = v.a; req1_b = v.b; req1_sel = v.sel; req1_valid = 1'b1;
        end else begin
            req0_a = v.a; req0_b = v.b; req0_sel = v.sel; req0_valid = 1'b1;
        end
        #1;
        chk("vec_grant_ready", 32'({req1_ready, req0_ready}), v.id ? 32'd2 : 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("vec_exec_readies", 32'({req1_ready, req0_ready}), 32'd0);
        chk("vec_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("vec_alu_a", 32'(alu_a), 32'(v.a));
        chk("vec_alu_b", 32'(alu_b), 32'(v.b));
        chk("vec_alu_sel", 32'(alu_sel), 32'(v.sel));
        @(negedge clk); #1;
        chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("vec_rsp_id", 32'(rsp_id), 32'(v.id));
        chk("vec_rsp_data", 32'(rsp_data), 32'(v.exp_data));
        chk("vec_rsp_carry", 32'(rsp_carry), 32'(v.exp_carry));
        @(negedge clk); #1;
        chk("vec_done_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("vec_alu_a_hold", 32'(alu_a), 32'(v.a));
        force_c = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        logic exp_id;
        checks = 0;
        failures = 0;

        vecs[0] = '{1'b0, 8'hF0, 8'h20, 4'h0, 8'h10, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'h05, 8'h03, 4'h1, 8'h02, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'h0F, 8'hFF, 4'h8, 8'h0F, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h0F, 8'hF0, 4'h9, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h40, 8'h00, 4'h3, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h7F, 8'h01, 4'h0, 8'h80, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'h10, 8'h11, 4'h2, 8'h10, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 8'h10, 8'h10, 4'hF, 8'h01, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'hAA, 8'h55, 4'hA, 8'hFF, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 8'hFF, 8'hFF, 4'h0, 8'hFE, 1'b1, 1'b0};

        rst = 1'b1;
        force_c = 1'b0;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; req0_sel = 4'h0;
        req1_valid = 1'b1; req1_a = 8'h56; req1_b = 8'h78; req1_sel = 4'h1;

        // Reset state, with requests pending that must not be accepted.
        @(negedge clk); #1;
        chk("rst_readies", 32'({req1_ready, req0_ready}), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
        chk("rst_alu_ops", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("idle_no_req_readies", 32'({req1_ready, req0_ready}), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Both requesters valid continuously; last winner was requester 1.
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_a = 8'h0F; req0_b = 8'hFF; req0_sel = 4'h8; req0_valid = 1'b1;
        req1_a = 8'h0F; req1_b = 8'hF0; req1_sel = 4'h9; req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            exp_id = 1'b0;
`else
            exp_id = k[0];
`endif
            chk("rr_ready", 32'({req1_ready, req0_ready}), exp_id ? 32'd2 : 32'd1);
            n = 1;
            while (rsp_valid !== 1'b1 && n < 20) begin
                @(negedge clk); #1;
                n++;
            end
            chk("rr_latency", 32'(n), 32'd3);
            chk("rr_id", 32'(rsp_id), 32'(exp_id));
            chk("rr_data", 32'(rsp_data), exp_id ? 32'hFF : 32'h0F);
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            @(negedge clk); #1;
        end

        // Backpressure: response held for 5 cycles with requester 1 waiting.
        rsp_ready = 1'b0;
        req0_a = 8'h33; req0_b = 8'h11; req0_sel = 4'h0; req0_valid = 1'b1;
        #1;
        chk("bp_grant", 32'({req1_ready, req0_ready}), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_a = 8'h01; req1_b = 8'h02; req1_sel = 4'h0; req1_valid = 1'b1;
        @(negedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'h44);
            chk("bp_rsp_id", 32'(rsp_id), 32'd0);
            chk("bp_readies", 32'({req1_ready, req0_ready}), 32'd0);
            chk("bp_alu_a", 32'(alu_a), 32'h33);
            @(negedge clk); #1;
        end
        chk("bp_still_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp_idle_grant1", 32'({req1_ready, req0_ready}), 32'd2);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk); #1;
        chk("bp_req1_valid", 32'(rsp_valid), 32'd1);
        chk("bp_req1_id", 32'(rsp_id), 32'd1);
        chk("bp_req1_data", 32'(rsp_data), 32'h03);
        @(negedge clk); #1;

        // Reset during EXEC discards the operation.
        req0_a = 8'h10; req0_b = 8'h10; req0_sel = 4'hF; req0_valid = 1'b1;
        #1;
        chk("mid_rst_grant", 32'({req1_ready, req0_ready}), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("mid_rst_exec_sel", 32'(alu_sel), 32'hF);
        rst = 1'b1;
        #1;
        chk("mid_rst_alu_ops", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        chk("mid_rst_rsp", 32'({rsp_valid, rsp_id, rsp_carry}), 32'd0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("mid_rst_readies", 32'({req1_ready, req0_ready}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (rsp_valid === 1'b1) seen++;
        end
        chk("mid_rst_no_response", 32'(seen), 32'd0);

        // After reset requester 0 wins a tie.
        req0_a = 8'h02; req0_b = 8'h03; req0_sel = 4'h0; req0_valid = 1'b1;
        req1_a = 8'h09; req1_b = 8'h01; req1_sel = 4'h1; req1_valid = 1'b1;
        #1;
        chk("post_rst_tie", 32'({req1_ready, req0_ready}), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_data", 32'(rsp_data), 32'h05);
        chk("post_rst_id", 32'(rsp_id), 32'd0);
        @(negedge clk); #1;
        chk("post_rst_done", 32'(rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
